vending_machine_multi: RTL
==========================

Name: vending_machine_multi

Overview:
Parametrised successor of the single-product vending FSM. Adds multiple selectable items with per-item prices and stock counters, a third coin denomination, explicit buy/cancel, an over-credit guard and multi-coin greedy change return (one coin per cycle). It sits between the coin acceptor and the dispense/change actuators; all outputs are registered.

Parameters:
NUM_ITEMS, 4, number of products (≥2)
SEL_W, 2, item select width (≥ clog2(NUM_ITEMS))
PRICE_W, 8, width of prices and credit register
PRICES, {8'd40,8'd30,8'd20,8'd15}, packed prices; item i at bits [i*PRICE_W +: PRICE_W]; each must be a multiple of 5
STOCK_W, 4, per-item stock counter width
STOCK_INIT, 3, stock loaded at reset and on restock
MAX_CREDIT, 60, credit ceiling (multiple of 5, < 2**PRICE_W)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in  in  2  coin: 0 none, 1 = 5, 2 = 10, 3 = 20; one coin per cycle
sel  in  SEL_W  item select, sampled with buy
buy  in  1  purchase request, single-cycle
cancel  in  1  refund request, single-cycle
restock  in  1  reload all stock counters to STOCK_INIT
out  out  1  one-cycle dispense pulse
item  out  SEL_W  index of the dispensed item, valid with out
change  out  2  returned coin, same encoding as in; 0 = none
credit  out  PRICE_W  current credit
busy  out  1  high in VEND/CHANGE; coins, buy, cancel ignored
sold_out  out  1  one-cycle pulse: buy rejected for zero stock

Behaviour:
- rst low (any time, including mid-vend or mid-change): state IDLE; out, item, change, credit, sold_out and busy are 0; all stock = STOCK_INIT. Partial credit is lost.
- States: IDLE (credit 0), COLLECT (credit>0), VEND, CHANGE.
- Coin (IDLE/COLLECT): v = coin value. If credit+v ≤ MAX_CREDIT, then credit += v and the state goes to COLLECT. Otherwise the coin is rejected: credit is unchanged and change = in for exactly the next cycle.
- eff = credit + v for an accepted coin in the same cycle as buy or cancel. Priority is restock (independent) > cancel > buy > coin-only.
- cancel with eff>0: credit = eff; go to CHANGE. cancel with eff=0: no effect.
- buy: if stock[sel]==0, then sold_out=1 for one cycle; credit = eff; stay or go to COLLECT.
- buy: if eff < PRICES[sel], the request is ignored; credit = eff.
- buy: else, at that edge out=1, item=sel, credit = eff − price, stock[sel] −= 1, state = VEND. out is high for exactly one cycle.
- VEND, next edge: out=0. If credit>0, go to CHANGE and emit the first coin at that same edge (first coin is visible the cycle after out). Otherwise go to IDLE.
- CHANGE: on each edge, emit the largest coin ≤ credit (20→3, 10→2, 5→1) and subtract its value. When credit==0, change=0 and the state goes to IDLE.
- Refund from cancel: the first coin appears one cycle after cancel is sampled.
- restock: applies at any state. If restock and a vend decrement coincide, restock wins.
- Stock counter never wraps below 0. Credit never exceeds MAX_CREDIT. Credit is always a multiple of 5.

Test Plan:
1. rst low, then in=2 twice, buy sel=0 → out=1 item=0 one cycle, credit 5; next cycle change=1 for one cycle, then change=0, credit 0, IDLE, busy low.
2. in=3,3,2 (credit 50), buy sel=2 → out with item=2, credit 20; next cycle change=3; then change=0, credit 0.
3. in=2, buy sel=3 → no out, credit 10; cancel → change=2 for one cycle, credit 0.
4. Four exact-15 purchases of item 0 → fourth gives sold_out pulse, no out, credit 15; restock, then buy sel=0 → out=1, credit 0.
5. in=3 ×3 (credit 60), then in=3 → credit stays 60, change=3 next cycle; then in=1 during busy → ignored.
6. Credit 50, buy sel=0 (change 35 due): assert rst low during the second change coin → all outputs 0 immediately, stock reloaded; after release, coin in=1 → credit 5.

Source files
------------

// File: rtl/vending_machine_multi.sv
// rtl/vending_machine_multi.sv - multi-item vending FSM with stock counters and greedy change return
module vending_machine_multi #(
    parameter int NUM_ITEMS = 4,
    parameter int SEL_W = 2,
    parameter int PRICE_W = 8,
    parameter logic [NUM_ITEMS*PRICE_W-1:0] PRICES = {8'd40, 8'd30, 8'd20, 8'd15},
    parameter int STOCK_W = 4,
    parameter int STOCK_INIT = 3,
    parameter int MAX_CREDIT = 60
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         in,
    input  logic [SEL_W-1:0]   sel,
    input  logic               buy,
    input  logic               cancel,
    input  logic               restock,
    output logic               out,
    output logic [SEL_W-1:0]   item,
    output logic [1:0]         change,
    output logic [PRICE_W-1:0] credit,
    output logic               busy,
    output logic               sold_out
);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    localparam logic [PRICE_W:0] MAXC = (PRICE_W+1)'(MAX_CREDIT);

    state_t               state, state_nxt;
    logic [PRICE_W-1:0]   credit_nxt;
    logic                 out_nxt, busy_nxt, sold_out_nxt, dec_en, accept;
    logic [SEL_W-1:0]     item_nxt;
    logic [1:0]           change_nxt, coin_out;
    logic [PRICE_W:0]     coin_v, sum;
    logic [PRICE_W-1:0]   eff, price, coin_sub;
    logic [STOCK_W-1:0]   sel_stock;
    logic [STOCK_W-1:0]   stock [NUM_ITEMS];

    // Unselectable indices leave sel_stock at zero, so such a buy reports sold_out.
    always_comb begin
        price = '0;
        sel_stock = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (SEL_W'(i) == sel) begin
                price = PRICES[i*PRICE_W +: PRICE_W];
                sel_stock = stock[i];
            end
        end
    end

    always_comb begin
        coin_v = '0;
        case (in)
            2'd1:    coin_v = (PRICE_W+1)'(5);
            2'd2:    coin_v = (PRICE_W+1)'(10);
            2'd3:    coin_v = (PRICE_W+1)'(20);
            default: coin_v = '0;
        endcase
        sum = {1'b0, credit} + coin_v;
        accept = (in != 2'd0) && (sum <= MAXC);
        eff = accept ? sum[PRICE_W-1:0] : credit;
    end

    // Greedy change: largest coin not exceeding the remaining credit.
    always_comb begin
        coin_out = 2'd0;
        coin_sub = '0;
        if (credit >= PRICE_W'(20)) begin
            coin_out = 2'd3;
            coin_sub = PRICE_W'(20);
        end else if (credit >= PRICE_W'(10)) begin
            coin_out = 2'd2;
            coin_sub = PRICE_W'(10);
        end else if (credit >= PRICE_W'(5)) begin
            coin_out = 2'd1;
            coin_sub = PRICE_W'(5);
        end
    end

    always_comb begin
        state_nxt = state;
        credit_nxt = credit;
        out_nxt = 1'b0;
        item_nxt = item;
        change_nxt = 2'd0;
        sold_out_nxt = 1'b0;
        dec_en = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                if (in != 2'd0 && !accept)
                    change_nxt = in;
                credit_nxt = eff;
                state_nxt = (eff != '0) ? COLLECT : IDLE;
                if (cancel) begin
                    if (eff != '0)
                        state_nxt = CHANGE;
                end else if (buy) begin
                    if (sel_stock == '0) begin
                        sold_out_nxt = 1'b1;
                    end else if (eff >= price) begin
                        out_nxt = 1'b1;
                        item_nxt = sel;
                        credit_nxt = eff - price;
                        dec_en = 1'b1;
                        state_nxt = VEND;
                    end
                end
            end
            VEND, CHANGE: begin
                if (credit != '0) begin
                    change_nxt = coin_out;
                    credit_nxt = credit - coin_sub;
                    state_nxt = CHANGE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt == VEND) || (state_nxt == CHANGE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            credit <= '0;
            out <= 1'b0;
            item <= '0;
            change <= 2'd0;
            busy <= 1'b0;
            sold_out <= 1'b0;
        end else begin
            state <= state_nxt;
            credit <= credit_nxt;
            out <= out_nxt;
            item <= item_nxt;
            change <= change_nxt;
            busy <= busy_nxt;
            sold_out <= sold_out_nxt;
        end
    end

    // Restock overrides a coincident vend decrement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ITEMS; i++)
                stock[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (restock)
                    stock[i] <= STOCK_W'(STOCK_INIT);
                else if (dec_en && SEL_W'(i) == sel && stock[i] != '0)
                    stock[i] <= stock[i] - 1'b1;
            end
        end
    end

endmodule
